// File: rtl/hamming_enc_fifo.sv
// Hamming SEC / SEC-DED encoder feeding a DEPTH-entry output FIFO; HAMMING_ENC_ERRINJ_EN adds an iInjMask error-injection port.
// Latency: 1 cycle from accept to oValid when the FIFO is empty. There is no combinational path from iData to oData.
// Backpressure: oReady drops while the FIFO is full. A pop in that cycle frees the slot for the following cycle only.
module hamming_enc_fifo #(
    parameter int DATA_W = 16,
    parameter int SECDED = 1,
    parameter int DEPTH  = 2,
    localparam int PAR_W = (DATA_W <= 1)  ? 2 :
                           (DATA_W <= 4)  ? 3 :
                           (DATA_W <= 11) ? 4 :
                           (DATA_W <= 26) ? 5 : 6,
    localparam int CODE_W = DATA_W + PAR_W + SECDED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] iData,
    input  logic              iValid,
    output logic              oReady,
    output logic [CODE_W-1:0] oData,
    output logic              oValid,
    input  logic              iReady
`ifdef HAMMING_ENC_ERRINJ_EN
    ,
    input  logic [CODE_W-1:0] iInjMask
`endif
);

    localparam int HAM_N = DATA_W + PAR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        int di;
        c  = '0;
        di = 0;
        for (int pos = 1; pos <= HAM_N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[di];
                di++;
            end
        end
        // Parity slots are still zero here, so they drop out of their own XOR.
        for (int k = 0; k < PAR_W; k++) begin
            logic p;
            p = 1'b0;
            for (int pos = 1; pos <= HAM_N; pos++) begin
                if (pos[k]) p = p ^ c[pos-1];
            end
            c[(1 << k) - 1] = p;
        end
        if (SECDED != 0) c[CODE_W-1] = ^c[HAM_N-1:0];
        return c;
    endfunction

    logic [CODE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic [CODE_W-1:0] storeWord;
    logic              push;
    logic              pop;

`ifdef HAMMING_ENC_ERRINJ_EN
    assign storeWord = encode(iData) ^ iInjMask;
`else
    assign storeWord = encode(iData);
`endif

    assign oReady = (count != FULL_CNT);
    assign oValid = (count != '0);
    assign push   = iValid & oReady;
    assign pop    = oValid & iReady;
    // Masking keeps oData at zero in reset without clearing the storage.
    assign oData  = oValid ? mem[rdPtr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= storeWord;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_enc_fifo.sv
// Directed bench for hamming_enc_fifo: three instances (defaults, SECDED=0, DEPTH=4).
// Honours HAMMING_ENC_ERRINJ_EN by connecting iInjMask and adjusting the expected codeword.
module tb_hamming_enc_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] iData = '0;
    logic        iValid = 1'b0;
    logic        iReady = 1'b0;
    logic [21:0] injMask = '0;
    logic        oReady0, oValid0, oReady1, oValid1;
    logic [21:0] oData0;
    logic [20:0] oData1;

    logic [15:0] d2Data = '0;
    logic        d2Valid = 1'b0;
    logic        d2Ready = 1'b0;
    logic        oReady2, oValid2;
    logic [21:0] oData2;

    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    hamming_enc_fifo #(.DATA_W(16), .SECDED(1), .DEPTH(2)) dut0 (
        .clk(clk), .rst(rst), .iData(iData), .iValid(iValid), .oReady(oReady0),
        .oData(oData0), .oValid(oValid0), .iReady(iReady)
`ifdef HAMMING_ENC_ERRINJ_EN
        , .iInjMask(injMask)
`endif
    );

    hamming_enc_fifo #(.DATA_W(16), .SECDED(0), .DEPTH(2)) dut1 (
        .clk(clk), .rst(rst), .iData(iData), .iValid(iValid), .oReady(oReady1),
        .oData(oData1), .oValid(oValid1), .iReady(iReady)
`ifdef HAMMING_ENC_ERRINJ_EN
        , .iInjMask(injMask[20:0])
`endif
    );

    hamming_enc_fifo #(.DATA_W(16), .SECDED(1), .DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .iData(d2Data), .iValid(d2Valid), .oReady(oReady2),
        .oData(oData2), .oValid(oValid2), .iReady(d2Ready)
`ifdef HAMMING_ENC_ERRINJ_EN
        , .iInjMask(22'h0)
`endif
    );

    // Reference encoder: parity bits are the XOR of the positions of all set data bits.
    function automatic logic [21:0] golden(input logic [15:0] d, input int secded);
        logic [20:0] c;
        logic [4:0]  syn;
        logic [4:0]  pv;
        int di;
        c = '0; syn = '0; di = 0;
        for (int pos = 1; pos <= 21; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                pv = 5'(pos);
                c[pos-1] = d[di];
                if (d[di]) syn = syn ^ pv;
                di++;
            end
        end
        for (int k = 0; k < 5; k++) c[(1 << k) - 1] = syn[k];
        return (secded != 0) ? {^c, c} : {1'b0, c};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic [21:0] exp22;
        logic [20:0] exp21;
    } vec_t;

    vec_t vecs [5];
    logic [15:0] w [20];
    logic [15:0] wa, wb, wc;

    initial begin
        vecs[0] = '{16'h0000, 22'h000000, 21'h000000};
        vecs[1] = '{16'h0001, 22'h200007, 21'h000007};
        vecs[2] = '{16'hFFFF, 22'h1FFFFE, 21'h1FFFFE};
        vecs[3] = '{16'h0002, 22'h200019, 21'h000019};
        vecs[4] = '{16'h8000, 22'h108009, 21'h108009};

        // Reset and idle defaults
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1; iReady = 1'b1;
        @(posedge clk); #1;
        check("rst_oValid", oValid0, 0);
        check("rst_oReady", oReady0, 1);
        check("rst_oData", oData0, 0);
        check("rst_oValid_d4", oValid2, 0);

        // Asynchronous reset mid-stream
        @(negedge clk) iData = 16'h5A5A; iValid = 1'b1; iReady = 1'b0;
        @(posedge clk); #1;
        iValid = 1'b0;
        check("pre_arst_oValid", oValid0, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_oValid", oValid0, 0);
        check("arst_oReady", oReady0, 1);
        check("arst_oData", oData0, 0);
        @(negedge clk) rst = 1'b1;

        // Encoding table on SEC-DED and SEC instances; back-to-back push/pop
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) iData = vecs[i].data; iValid = 1'b1; iReady = 1'b1;
            @(posedge clk); #1;
            iValid = 1'b0;
            check($sformatf("vec%0d_oValid", i), oValid0, 1);
            check($sformatf("vec%0d_secded", i), oData0, vecs[i].exp22);
            check($sformatf("vec%0d_sec", i), oData1, vecs[i].exp21);
        end
        @(posedge clk); #1;
        check("drain_oValid", oValid0, 0);

        // Full FIFO: third word held off, pop frees a slot for the next cycle
        wa = 16'h1234; wb = 16'hABCD; wc = 16'h0F0F;
        @(negedge clk) iReady = 1'b0; iData = wa; iValid = 1'b1;
        @(posedge clk); #1;
        check("full_first_oReady", oReady0, 1);
        check("full_first_oData", oData0, golden(wa, 1));
        @(negedge clk) iData = wb;
        @(posedge clk); #1;
        check("full_oReady", oReady0, 0);
        @(negedge clk) iData = wc;
        @(posedge clk); #1;
        check("full_hold_oReady", oReady0, 0);
        check("full_hold_oData", oData0, golden(wa, 1));
        @(negedge clk) iReady = 1'b1;
        @(posedge clk); #1;
        check("pop_reassert_oReady", oReady0, 1);
        check("pop_head_oData", oData0, golden(wb, 1));
        @(negedge clk) iReady = 1'b0;
        @(posedge clk); #1;
        check("third_accept_oReady", oReady0, 0);
        @(negedge clk) iValid = 1'b0; iReady = 1'b1;
        @(posedge clk); #1;
        check("order_third_oData", oData0, golden(wc, 1));
        check("order_third_oValid", oValid0, 1);
        @(posedge clk); #1;
        check("order_empty_oValid", oValid0, 0);

        // Streaming throughput on DEPTH=4 with pointer wrap
        for (int i = 0; i < 20; i++) w[i] = 16'($urandom_range(0, 16'hFFFF));
        d2Ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk) d2Data = w[i]; d2Valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("stream%0d_oValid", i), oValid2, 1);
            check($sformatf("stream%0d_oData", i), oData2, golden(w[i], 1));
            check($sformatf("stream%0d_oReady", i), oReady2, 1);
        end
        @(negedge clk) d2Valid = 1'b0;
        @(posedge clk); #1;
        check("stream_drain_oValid", oValid2, 0);

        // Error-injection mask (ignored in the default build)
        @(negedge clk) iData = 16'h0001; injMask = 22'h000008; iValid = 1'b1; iReady = 1'b1;
        @(posedge clk); #1;
        iValid = 1'b0;
        injMask = '0;
`ifdef HAMMING_ENC_ERRINJ_EN
        check("inj_secded", oData0, 22'h20000F);
        check("inj_sec", oData1, 21'h00000F);
`else
        check("inj_secded", oData0, 22'h200007);
        check("inj_sec", oData1, 21'h000007);
`endif
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/hamming_enc_fifo.md
Name: hamming_enc_fifo

Overview:
Parametrised successor to the fixed 16-to-21-bit Hamming encoder. Encodes DATA_W-bit words into Hamming SEC codewords, or SEC-DED codewords when SECDED=1. Each codeword is buffered in a DEPTH-entry output FIFO, so the upstream producer keeps streaming while the downstream consumer stalls. Sits between the data source and the channel/serialiser using the existing iValid/oReady, oValid/iReady handshake.

Parameters:
DATA_W, 16, data word width; 1..57.
SECDED, 1, 1 = append an overall even-parity bit (SEC-DED); 0 = plain SEC.
DEPTH, 2, output FIFO entries; power of two, >= 2.
PAR_W (localparam), derived, smallest r with 2^r >= DATA_W + r + 1; 5 for DATA_W=16.
CODE_W (localparam), derived, DATA_W + PAR_W + SECDED; 22 for the defaults, 21 with SECDED=0.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
iData  in  DATA_W  data word to encode.
iValid  in  1  iData valid.
oReady  out  1  encoder can accept a word; equals FIFO not full.
oData  out  CODE_W  codeword at the FIFO head.
oValid  out  1  oData valid; equals FIFO not empty.
iReady  in  1  downstream accepts oData.

Behaviour:
- Reset (rst low, asynchronous): FIFO empty, read/write pointers 0, oValid=0, oReady=1, oData=0. Storage contents need not be cleared.
- Accept: iValid & oReady at a rising edge. The codeword is computed combinationally from iData and written at the write pointer.
- Pop: oValid & iReady at a rising edge. Advances the read pointer.
- Latency: a word accepted at edge N appears on oData with oValid=1 after edge N. This gives 1 cycle to an empty FIFO. There is no combinational path from iData to oData.
- oData is the stored head entry. It is stable while oValid=1 and iReady=0.
- Codeword layout: Hamming positions 1..DATA_W+PAR_W map to oData[pos-1].
  - Parity bit p_k sits at position 2^k. It is the even parity (XOR) of all positions with bit k set.
  - Data bits fill the non-power-of-two positions in ascending order, iData[0] first.
  - When SECDED=1, oData[CODE_W-1] is the XOR of oData[CODE_W-2:0].
- Occupancy: counter of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- Full: oReady=0, so iValid is ignored. A pop in the same cycle does not allow a push; oReady reasserts the cycle after the pop.
- Empty: oValid=0; iReady is ignored.
- Simultaneous push and pop when neither full nor empty: both pointers advance and the count is unchanged.
- Handshake rules:
  - Upstream may change iData freely when the word is not accepted.
  - oValid never drops without a pop, except on reset.
- Reset mid-operation: contents discarded immediately (asynchronous). Outputs return to reset values without waiting for a clock.

Optional Feature:
Macro HAMMING_ENC_ERRINJ_EN.
- Defined: adds input port iInjMask [CODE_W-1:0]. At accept, the stored codeword is the computed codeword XOR iInjMask. This lets the decoder bench inject single and double errors.
- Undefined: the port does not exist and codewords are stored unmodified.
- Encoding, latency and handshake are identical in both builds.

Test Plan:
1. Reset then idle, defaults, iReady=1: oValid=0, oReady=1, oData=0. Assert rst low mid-stream: oValid drops with no clock edge.
2. Defaults, push 16'h0000, 16'h0001, 16'hFFFF, iReady=1: oData=22'h000000, 22'h200007, 22'h1FFFFE in order. Each appears one cycle after accept.
3. SECDED=0 build, same three words: 21'h000000, 21'h000007, 21'h1FFFFE.
4. DEPTH=2, iReady=0, push 3 words back-to-back: oReady=0 after the 2nd accept and the 3rd is held off. Pulse iReady for 1 cycle: head pops, oReady=1 the next cycle, 3rd word accepted. Order is preserved and nothing is dropped or duplicated.
5. DEPTH=4, iValid=1 and iReady=1 continuously with 20 random words: one word per cycle throughput, output sequence equals the golden-model encodings. Occupancy wraps the pointers at least 5 times.
6. HAMMING_ENC_ERRINJ_EN build, push 16'h0001 with iInjMask=22'h000008: oData=22'h20000F. Undefined build: the same stimulus without the port gives 22'h200007.
